exception_unit_core: RTL and testbench
======================================

EXCEPTION_UNIT_CORE -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all sequential logic.
REQ-002 SHALL have port reset, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port if_pc, input, 32, PC of the IF-stage instruction.
REQ-004 SHALL have port if_valid, input, 1, IF stage holds a valid instruction.
REQ-005 SHALL have ports id_illegal_inst / id_ecall / id_ebreak, input, 1 each, ID decode flags.
REQ-006 SHALL have ports id_pc / id_instruction, input, 32 each, ID-stage PC and instruction word.
REQ-007 SHALL have port id_valid, input, 1, ID stage valid.
REQ-008 SHALL have ports mem_addr / mem_pc / mem_instruction, input, 32 each, MEM effective address, PC and instruction word.
REQ-009 SHALL have ports mem_read / mem_write, input, 1 each, MEM load/store strobes.
REQ-010 SHALL have port mem_funct3, input, 3, load/store width code.
REQ-011 SHALL have port mem_valid, input, 1, MEM stage valid.
REQ-012 SHALL have port exc_clear, input, 1, clears the capture record.
REQ-013 SHALL have port exception, output, 1, combinational exception detected.
REQ-014 SHALL have ports exception_code, output, 5, and exception_pc / exception_val, output, 32 each, combinational cause, faulting PC and trap value.
REQ-015 SHALL have ports cap_valid, output, 1, and cap_code, output, 5, and cap_pc / cap_val, output, 32 each, registered first-exception record.
REQ-016 SHALL have port exc_count, output, 16, saturating count of cycles with exception=1.

Function
REQ-017 SHALL drive exception, exception_code, exception_pc and exception_val purely combinationally, with zero latency and no dependence on clk.
REQ-018 SHALL flag IF misaligned when if_valid=1 and if_pc[1:0]!=0: code 0, pc=if_pc, val=if_pc.
REQ-019 SHALL flag illegal instruction when id_valid=1 and id_illegal_inst=1: code 2, pc=id_pc, val=id_instruction.
REQ-020 SHALL flag EBREAK when id_valid=1 and id_ebreak=1: code 3, pc=id_pc, val=id_pc.
REQ-021 SHALL flag ECALL when id_valid=1 and id_ecall=1: code 11, pc=id_pc, val=0.
REQ-022 SHALL classify mem_funct3[1:0] as 00=byte (never misaligned), 01=half (misaligned if addr[0]), 10 or 11=word (misaligned if addr[1:0]!=0).
REQ-023 SHALL flag load misaligned when mem_valid and mem_read and the access is misaligned: code 4, pc=mem_pc, val=mem_addr.
REQ-024 SHALL flag store misaligned when mem_valid and mem_write and the access is misaligned: code 6, pc=mem_pc, val=mem_addr.
REQ-025 SHALL apply priority IF misaligned > illegal > EBREAK > ECALL > load misaligned > store misaligned.
REQ-026 SHALL drive exception=0 and code/pc/val all zero when no source is active; a flag with its stage valid=0 SHALL be ignored.
REQ-027 SHALL, on a rising clk edge with exception=1 and cap_valid=0, load cap_code/cap_pc/cap_val from the combinational outputs and set cap_valid=1.
REQ-028 SHALL hold the capture record while cap_valid=1 and ignore later exceptions until cleared.
REQ-029 SHALL, when exc_clear=1 at a clk edge, clear cap_valid; clear SHALL take precedence over a simultaneous capture.
REQ-030 SHALL increment exc_count on each clk edge with exception=1, saturating at 16'hFFFF; exc_clear SHALL NOT affect exc_count.

Reset
REQ-031 SHALL, while reset=1, asynchronously force cap_valid=0, cap_code=0, cap_pc=0, cap_val=0 and exc_count=0.
REQ-032 SHALL NOT let reset affect the combinational outputs.

Configuration
REQ-033 SHALL compile in compressed-instruction alignment when EXC_RVC_EN is defined: IF misaligned only when if_pc[0]=1.
REQ-034 SHALL, without EXC_RVC_EN, check IF alignment on if_pc[1:0]!=0 as in REQ-018.

Verification
REQ-035 SHALL cover if_pc=0x102 with if_valid=1 and id_illegal_inst=1, id_valid=1, id_pc=0x200: response exception=1, code=0, pc=0x102, val=0x102.
REQ-036 SHALL cover id_ebreak=1 and id_ecall=1 with id_pc=0x500: response code=3; ecall alone at 0x300: response code=11, val=0.
REQ-037 SHALL cover LW at 0x10000002 with mem_pc=0x600: response code=4, val=0x10000002; LB at 0x10000003: response exception=0; LH at 0x10000002: response exception=0.
REQ-038 SHALL cover illegal at 0x600 plus SW at 0x10000001: response code=2, pc=0x600; SW alone: response code=6.
REQ-039 SHALL cover id_illegal_inst=1 with id_valid=0: response exception=0.
REQ-040 SHALL cover two successive exceptions over clocks: response record holds the first; exc_clear re-arms capture; exc_count=2; reset mid-run zeroes all registers.

Source files
------------

// File: rtl/exception_unit_core.sv
// rtl/exception_unit_core.sv - prioritised exception detector with first-exception capture and saturating counter (option: EXC_RVC_EN)
module exception_unit_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        id_illegal_inst,
  input  logic        id_ecall,
  input  logic        id_ebreak,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instruction,
  input  logic        id_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_instruction,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic        mem_valid,
  input  logic        exc_clear,
  output logic        exception,
  output logic [4:0]  exception_code,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_val,
  output logic        cap_valid,
  output logic [4:0]  cap_code,
  output logic [31:0] cap_pc,
  output logic [31:0] cap_val,
  output logic [15:0] exc_count
);

  localparam logic [4:0] CODE_IF_MISALIGN = 5'd0;
  localparam logic [4:0] CODE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CODE_EBREAK      = 5'd3;
  localparam logic [4:0] CODE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CODE_ST_MISALIGN = 5'd6;
  localparam logic [4:0] CODE_ECALL       = 5'd11;

  logic if_misaligned;
  logic mem_misaligned;

  // The instruction word in MEM and the unsigned bit of funct3 carry no alignment information.
  logic unused_bits;
  assign unused_bits = ^{mem_instruction, mem_funct3[2]};

`ifdef EXC_RVC_EN
  // With compressed instructions, fetch only needs halfword alignment.
  assign if_misaligned = if_valid && if_pc[0];
`else
  // Without compressed instructions, fetch must be word aligned.
  assign if_misaligned = if_valid && (if_pc[1:0] != 2'b00);
`endif

  // Access width comes from funct3[1:0]: byte never faults, half needs bit 0 clear, word needs both low bits clear.
  always_comb begin
    mem_misaligned = 1'b0;
    case (mem_funct3[1:0])
      2'b00:   mem_misaligned = 1'b0;
      2'b01:   mem_misaligned = mem_addr[0];
      default: mem_misaligned = (mem_addr[1:0] != 2'b00);
    endcase
  end

  // Priority chain from oldest pipeline concern (fetch) down to memory stores; idle outputs read as zero.
  always_comb begin
    exception      = 1'b0;
    exception_code = 5'd0;
    exception_pc   = 32'd0;
    exception_val  = 32'd0;
    if (if_misaligned) begin
      exception      = 1'b1;
      exception_code = CODE_IF_MISALIGN;
      exception_pc   = if_pc;
      exception_val  = if_pc;
    end else if (id_valid && id_illegal_inst) begin
      exception      = 1'b1;
      exception_code = CODE_ILLEGAL;
      exception_pc   = id_pc;
      exception_val  = id_instruction;
    end else if (id_valid && id_ebreak) begin
      exception      = 1'b1;
      exception_code = CODE_EBREAK;
      exception_pc   = id_pc;
      exception_val  = id_pc;
    end else if (id_valid && id_ecall) begin
      exception      = 1'b1;
      exception_code = CODE_ECALL;
      exception_pc   = id_pc;
      exception_val  = 32'd0;
    end else if (mem_valid && mem_read && mem_misaligned) begin
      exception      = 1'b1;
      exception_code = CODE_LD_MISALIGN;
      exception_pc   = mem_pc;
      exception_val  = mem_addr;
    end else if (mem_valid && mem_write && mem_misaligned) begin
      exception      = 1'b1;
      exception_code = CODE_ST_MISALIGN;
      exception_pc   = mem_pc;
      exception_val  = mem_addr;
    end
  end

  // First-exception record: clear beats a same-edge capture; once valid, later exceptions are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_code  <= 5'd0;
      cap_pc    <= 32'd0;
      cap_val   <= 32'd0;
    end else if (exc_clear) begin
      cap_valid <= 1'b0;
    end else if (exception && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_code  <= exception_code;
      cap_pc    <= exception_pc;
      cap_val   <= exception_val;
    end
  end

  // Count exception cycles, sticking at all-ones; exc_clear deliberately leaves the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_count <= 16'd0;
    end else if (exception && (exc_count != 16'hFFFF)) begin
      exc_count <= exc_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_exception_unit_core.sv
// tb/tb_exception_unit_core.sv - vector-table and sequence bench for exception_unit_core
module tb_exception_unit_core;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        id_illegal_inst;
  logic        id_ecall;
  logic        id_ebreak;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_pc;
  logic [31:0] mem_instruction;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic        mem_valid;
  logic        exc_clear;
  logic        exception;
  logic [4:0]  exception_code;
  logic [31:0] exception_pc;
  logic [31:0] exception_val;
  logic        cap_valid;
  logic [4:0]  cap_code;
  logic [31:0] cap_pc;
  logic [31:0] cap_val;
  logic [15:0] exc_count;

  exception_unit_core dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .if_valid(if_valid),
    .id_illegal_inst(id_illegal_inst), .id_ecall(id_ecall), .id_ebreak(id_ebreak),
    .id_pc(id_pc), .id_instruction(id_instruction), .id_valid(id_valid),
    .mem_addr(mem_addr), .mem_pc(mem_pc), .mem_instruction(mem_instruction),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_valid(mem_valid),
    .exc_clear(exc_clear),
    .exception(exception), .exception_code(exception_code),
    .exception_pc(exception_pc), .exception_val(exception_val),
    .cap_valid(cap_valid), .cap_code(cap_code), .cap_pc(cap_pc), .cap_val(cap_val),
    .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        illegal;
    logic        ecall;
    logic        ebreak;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_pc;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        mem_valid;
    logic        exp_exc;
    logic [4:0]  exp_code;
    logic [31:0] exp_pc;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[$];
  int tests;
  int fails;

  function automatic vec_t mk(string name,
      logic [31:0] ipc, logic iv, logic ill, logic ec, logic eb,
      logic [31:0] dpc, logic [31:0] dinst, logic dv,
      logic [31:0] ma, logic [31:0] mpc, logic mr, logic mw, logic [2:0] f3, logic mv,
      logic ee, logic [4:0] ecode, logic [31:0] epc, logic [31:0] evl);
    vec_t v;
    v.name = name; v.if_pc = ipc; v.if_valid = iv; v.illegal = ill; v.ecall = ec; v.ebreak = eb;
    v.id_pc = dpc; v.id_inst = dinst; v.id_valid = dv;
    v.mem_addr = ma; v.mem_pc = mpc; v.mem_read = mr; v.mem_write = mw; v.funct3 = f3; v.mem_valid = mv;
    v.exp_exc = ee; v.exp_code = ecode; v.exp_pc = epc; v.exp_val = evl;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(vec_t v);
    if_pc = v.if_pc; if_valid = v.if_valid;
    id_illegal_inst = v.illegal; id_ecall = v.ecall; id_ebreak = v.ebreak;
    id_pc = v.id_pc; id_instruction = v.id_inst; id_valid = v.id_valid;
    mem_addr = v.mem_addr; mem_pc = v.mem_pc; mem_instruction = 32'h0000_0013;
    mem_read = v.mem_read; mem_write = v.mem_write; mem_funct3 = v.funct3; mem_valid = v.mem_valid;
  endtask

  task automatic check_comb(vec_t v);
    check({v.name, ".exc"},  {31'd0, exception},      {31'd0, v.exp_exc});
    check({v.name, ".code"}, {27'd0, exception_code}, {27'd0, v.exp_code});
    check({v.name, ".pc"},   exception_pc,            v.exp_pc);
    check({v.name, ".val"},  exception_val,           v.exp_val);
  endtask

  task automatic check_regs_zero(string name);
    check({name, ".cap_valid"}, {31'd0, cap_valid}, 32'd0);
    check({name, ".cap_code"},  {27'd0, cap_code},  32'd0);
    check({name, ".cap_pc"},    cap_pc,             32'd0);
    check({name, ".cap_val"},   cap_val,            32'd0);
    check({name, ".count"},     {16'd0, exc_count}, 32'd0);
  endtask

  vec_t v_none, v_ecall, v_ebreak, v_sw;

  initial begin
    tests = 0;
    fails = 0;

    //         name        if_pc        iv ill ec eb id_pc        id_inst      dv mem_addr     mem_pc       mr mw f3    mv   exc code   pc           val
    vecs.push_back(mk("idle",       32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        32'h0,   0, 0, 3'd0, 0,   0, 5'd0,  32'h0,   32'h0));
    vecs.push_back(mk("if_vs_ill",  32'h102,     1, 1, 0, 0, 32'h200, 32'hFFFFFFFF, 1, 32'h0,        32'h0,   0, 0, 3'd0, 0,   1, 5'd0,  32'h102, 32'h102));
    vecs.push_back(mk("if_odd",     32'h101,     1, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        32'h0,   0, 0, 3'd0, 0,   1, 5'd0,  32'h101, 32'h101));
    vecs.push_back(mk("illegal",    32'h100,     1, 1, 0, 0, 32'h200, 32'hFFFFFFFF, 1, 32'h0,        32'h0,   0, 0, 3'd0, 0,   1, 5'd2,  32'h200, 32'hFFFFFFFF));
    vecs.push_back(mk("ebrk_ecall", 32'h0,       0, 0, 1, 1, 32'h500, 32'h00100073, 1, 32'h0,        32'h0,   0, 0, 3'd0, 0,   1, 5'd3,  32'h500, 32'h500));
    vecs.push_back(mk("ecall",      32'h0,       0, 0, 1, 0, 32'h300, 32'h00000073, 1, 32'h0,        32'h0,   0, 0, 3'd0, 0,   1, 5'd11, 32'h300, 32'h0));
    vecs.push_back(mk("lw_mis",     32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000002, 32'h600, 1, 0, 3'd2, 1,   1, 5'd4,  32'h600, 32'h10000002));
    vecs.push_back(mk("lb_ok",      32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000003, 32'h600, 1, 0, 3'd0, 1,   0, 5'd0,  32'h0,   32'h0));
    vecs.push_back(mk("lh_ok",      32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000002, 32'h600, 1, 0, 3'd1, 1,   0, 5'd0,  32'h0,   32'h0));
    vecs.push_back(mk("lh_mis",     32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000001, 32'h604, 1, 0, 3'd1, 1,   1, 5'd4,  32'h604, 32'h10000001));
    vecs.push_back(mk("lhu_mis",    32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000003, 32'h608, 1, 0, 3'd5, 1,   1, 5'd4,  32'h608, 32'h10000003));
    vecs.push_back(mk("ill_vs_sw",  32'h0,       0, 1, 0, 0, 32'h600, 32'h12345678, 1, 32'h10000001, 32'h700, 0, 1, 3'd2, 1,   1, 5'd2,  32'h600, 32'h12345678));
    vecs.push_back(mk("sw_mis",     32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000001, 32'h700, 0, 1, 3'd2, 1,   1, 5'd6,  32'h700, 32'h10000001));
    vecs.push_back(mk("f3_3_st",    32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h20000002, 32'h704, 0, 1, 3'd3, 1,   1, 5'd6,  32'h704, 32'h20000002));
    vecs.push_back(mk("ill_novld",  32'h0,       0, 1, 0, 0, 32'h200, 32'hFFFFFFFF, 0, 32'h0,        32'h0,   0, 0, 3'd0, 0,   0, 5'd0,  32'h0,   32'h0));
    vecs.push_back(mk("if_novld",   32'h103,     0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        32'h0,   0, 0, 3'd0, 0,   0, 5'd0,  32'h0,   32'h0));
    vecs.push_back(mk("lw_novld",   32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000002, 32'h600, 1, 0, 3'd2, 0,   0, 5'd0,  32'h0,   32'h0));
    vecs.push_back(mk("mem_nostrb", 32'h0,       0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h10000002, 32'h600, 0, 0, 3'd2, 1,   0, 5'd0,  32'h0,   32'h0));

    v_none   = vecs[0];
    v_ecall  = vecs[5];
    v_ebreak = vecs[4];
    v_sw     = vecs[12];

    exc_clear = 1'b0;
    drive(v_none);
    reset = 1'b1;
    #12;
    check_regs_zero("reset");

    // Combinational outputs must respond even while reset is held.
    drive(v_sw);
    #1;
    check_comb(v_sw);

    drive(v_none);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors are applied between edges so no capture or count is ever checked here.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check_comb(vecs[i]);
    end

    // Restart registers cleanly for the multi-cycle sequences.
    drive(v_none);
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    check_regs_zero("reset2");

    // Two successive exceptions: record keeps the first, count reaches two.
    @(negedge clk);
    drive(v_ecall);
    @(negedge clk);
    drive(v_ebreak);
    @(negedge clk);
    drive(v_none);
    check("seq.cap_valid", {31'd0, cap_valid}, 32'd1);
    check("seq.cap_code",  {27'd0, cap_code},  32'd11);
    check("seq.cap_pc",    cap_pc,             32'h300);
    check("seq.cap_val",   cap_val,            32'h0);
    check("seq.count",     {16'd0, exc_count}, 32'd2);

    // Clear coincides with an active exception: clear wins, but the cycle is still counted.
    drive(v_ebreak);
    exc_clear = 1'b1;
    @(negedge clk);
    exc_clear = 1'b0;
    check("clr.cap_valid", {31'd0, cap_valid}, 32'd0);
    check("clr.count",     {16'd0, exc_count}, 32'd3);

    // Re-armed: the next exception is captured.
    @(negedge clk);
    drive(v_none);
    check("rearm.cap_valid", {31'd0, cap_valid}, 32'd1);
    check("rearm.cap_code",  {27'd0, cap_code},  32'd3);
    check("rearm.cap_pc",    cap_pc,             32'h500);
    check("rearm.cap_val",   cap_val,            32'h500);
    check("rearm.count",     {16'd0, exc_count}, 32'd4);

    // Clear with no exception present must not touch the counter.
    exc_clear = 1'b1;
    @(negedge clk);
    exc_clear = 1'b0;
    check("clr2.cap_valid", {31'd0, cap_valid}, 32'd0);
    check("clr2.count",     {16'd0, exc_count}, 32'd4);

    // Reset asserted between edges must zero the registers without waiting for a clock.
    drive(v_sw);
    @(negedge clk);
    check("pre_rst.cap_valid", {31'd0, cap_valid}, 32'd1);
    check("pre_rst.cap_code",  {27'd0, cap_code},  32'd6);
    #1;
    reset = 1'b1;
    #1;
    check_regs_zero("async_rst");
    drive(v_none);
    @(negedge clk);
    reset = 1'b0;

    // Hold an exception long enough to hit the counter ceiling, then a little longer.
    drive(v_sw);
    exc_clear = 1'b1;
    for (int n = 0; n < 65534; n++) @(negedge clk);
    check("sat.count_fffe", {16'd0, exc_count}, 32'h0000FFFE);
    @(negedge clk);
    check("sat.count_ffff", {16'd0, exc_count}, 32'h0000FFFF);
    repeat (3) @(negedge clk);
    check("sat.count_hold", {16'd0, exc_count}, 32'h0000FFFF);
    check("sat.cap_valid",  {31'd0, cap_valid}, 32'd0);
    exc_clear = 1'b0;
    drive(v_none);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
